// File: rtl/drac_pkg.sv
// -----------------------------------------------------------------------------
// drac_pkg
// Shared types for the retirement path: the graduation-list entry, the pending
// exception record, the commit FSM state enum, trap causes, and the
// instruction classification helpers used by both the commit unit and the
// graduation list.
// -----------------------------------------------------------------------------
package drac_pkg;

  typedef logic [63:0] bus64_t;
  typedef logic [63:0] addrPC_t;
  typedef logic [11:0] reg_csr_addr_t;

  typedef enum logic [2:0] {
    INSTR_ALU,
    INSTR_LOAD,
    INSTR_STORE,
    INSTR_AMO,
    INSTR_CSR,
    INSTR_FENCE,
    INSTR_FENCE_I,
    INSTR_BRANCH
  } instr_type_t;

  typedef struct packed {
    logic        valid;
    addrPC_t     pc;
    instr_type_t instr_type;
    logic        ex_valid;
  } gl_instruction_t;

  typedef struct packed {
    bus64_t cause;
    bus64_t tval;
  } exception_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_CSR_WAIT,
    ST_FENCE_WAIT,
    ST_DRAIN
  } commit_state_t;

  localparam bus64_t CAUSE_ILLEGAL_INSTR = 64'd2;

  function automatic logic is_csr_instr(input gl_instruction_t instr);
    return instr.instr_type == INSTR_CSR;
  endfunction

  function automatic logic is_fence_instr(input gl_instruction_t instr);
    return (instr.instr_type == INSTR_FENCE) || (instr.instr_type == INSTR_FENCE_I);
  endfunction

  function automatic logic is_store_or_amo(input gl_instruction_t instr);
    return (instr.instr_type == INSTR_STORE) || (instr.instr_type == INSTR_AMO);
  endfunction

endpackage

// File: rtl/commit_unit_if.sv
// -----------------------------------------------------------------------------
// commit_unit_if
// Bundle between the commit unit, the graduation list and the CSR unit.
//   gl_instr_i       : slot 0 (head) and slot 1 (head+1) entries
//   gl_exception_i   : oldest pending exception (cause, tval)
//   gl_csr_addr_i    : CSR address of the instruction at the head
//   gl_result_i      : CSR write data of the instruction at the head
//   read_head_o      : retire mask back to the graduation list
//   csr_req_valid_o  : CSR access request, with csr_addr_o / csr_wdata_o
//   csr_resp_*_i     : CSR unit response (done, fault, refetch needed)
// master = commit unit side, slave = graduation list / CSR unit side.
// -----------------------------------------------------------------------------
interface commit_unit_if;
  import drac_pkg::*;

  gl_instruction_t [1:0] gl_instr_i;
  exception_t            gl_exception_i;
  reg_csr_addr_t         gl_csr_addr_i;
  bus64_t                gl_result_i;
  logic [1:0]            read_head_o;

  logic                  csr_req_valid_o;
  reg_csr_addr_t         csr_addr_o;
  bus64_t                csr_wdata_o;
  logic                  csr_resp_valid_i;
  logic                  csr_resp_xcpt_i;
  logic                  csr_resp_flush_i;

  modport master (
    input  gl_instr_i, gl_exception_i, gl_csr_addr_i, gl_result_i,
    input  csr_resp_valid_i, csr_resp_xcpt_i, csr_resp_flush_i,
    output read_head_o, csr_req_valid_o, csr_addr_o, csr_wdata_o
  );

  modport slave (
    output gl_instr_i, gl_exception_i, gl_csr_addr_i, gl_result_i,
    output csr_resp_valid_i, csr_resp_xcpt_i, csr_resp_flush_i,
    input  read_head_o, csr_req_valid_o, csr_addr_o, csr_wdata_o
  );

endinterface

// File: rtl/commit_unit.sv
// -----------------------------------------------------------------------------
// commit_unit
// Retirement controller behind the graduation list. Retires 0/1/2 oldest
// entries per cycle, serialises CSRs and fences, takes exceptions and
// interrupts precisely at the head, and raises the pipeline-wide flush.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   gl_if (master)      : graduation-list and CSR-unit bundle
//   interrupt_i         : level interrupt pending, cause in interrupt_cause_i
//   sb_empty_i          : store buffer drained
//   flush_commit_o      : one-cycle full pipeline flush
//   store_commit_o      : a retiring store/AMO is released to the store buffer
//   xcpt_valid_o/cause/tval/pc : trap taken this cycle
//   instret_inc_o       : instructions retired this cycle
//   fatal_o             : sticky CSR response timeout
// -----------------------------------------------------------------------------
module commit_unit
  import drac_pkg::*;
#(
  parameter int DUAL_COMMIT = 1,
  parameter int CSR_TIMEOUT = 1023
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  commit_unit_if.master        gl_if,
  input  logic                 interrupt_i,
  input  bus64_t               interrupt_cause_i,
  input  logic                 sb_empty_i,
  output logic                 flush_commit_o,
  output logic                 store_commit_o,
  output logic                 xcpt_valid_o,
  output bus64_t               xcpt_cause_o,
  output bus64_t               xcpt_tval_o,
  output addrPC_t              xcpt_pc_o,
  output logic [1:0]           instret_inc_o,
  output logic                 fatal_o
);

  localparam logic [9:0] TIMEOUT_C = 10'(CSR_TIMEOUT);

  commit_state_t   r_state;
  commit_state_t   w_next;
  logic [9:0]      r_csr_cnt;
  logic [9:0]      w_csr_cnt_inc;
  logic            r_fatal;
  logic            r_csr_req;
  reg_csr_addr_t   r_csr_addr;
  bus64_t          r_csr_wdata;

  gl_instruction_t w_s0;
  gl_instruction_t w_s1;
  logic            w_s1_ok;
  logic [1:0]      w_read_head;
  logic            w_flush;
  logic            w_xcpt;
  bus64_t          w_cause;
  bus64_t          w_tval;
  addrPC_t         w_pc;
  logic            w_unused;

  assign w_s0 = gl_if.gl_instr_i[0];
  assign w_s1 = gl_if.gl_instr_i[1];

  // Slot-1 pc only matters if slot 1 traps, which it never does from slot 1.
  assign w_unused = ^w_s1.pc;

  // Slot 1 may ride along with an ordinary slot 0 unless it needs the head
  // to itself, or both would compete for the single store port.
  assign w_s1_ok = (DUAL_COMMIT != 0) && w_s1.valid && !w_s1.ex_valid &&
                   !is_csr_instr(w_s1) && !is_fence_instr(w_s1) &&
                   !(is_store_or_amo(w_s0) && is_store_or_amo(w_s1));

  assign w_csr_cnt_inc = (r_csr_cnt == TIMEOUT_C) ? r_csr_cnt : r_csr_cnt + 10'd1;

  always_comb begin
    w_next      = r_state;
    w_read_head = 2'b00;
    w_flush     = 1'b0;
    w_xcpt      = 1'b0;
    w_cause     = '0;
    w_tval      = '0;
    w_pc        = '0;
    // Outputs are forced quiet while reset is held, even with a valid head.
    if (!rst_i) begin
      case (r_state)
        ST_RUN: begin
          if (w_s0.valid) begin
            if (interrupt_i) begin
              w_xcpt  = 1'b1;
              w_cause = interrupt_cause_i;
              w_pc    = w_s0.pc;
              w_flush = 1'b1;
              w_next  = ST_DRAIN;
            end else if (w_s0.ex_valid) begin
              w_xcpt  = 1'b1;
              w_cause = gl_if.gl_exception_i.cause;
              w_tval  = gl_if.gl_exception_i.tval;
              w_pc    = w_s0.pc;
              w_flush = 1'b1;
              w_next  = ST_DRAIN;
            end else if (is_csr_instr(w_s0)) begin
              w_next = ST_CSR_WAIT;
            end else if (is_fence_instr(w_s0)) begin
              w_next = ST_FENCE_WAIT;
            end else begin
              w_read_head = w_s1_ok ? 2'b11 : 2'b01;
            end
          end
        end
        ST_CSR_WAIT: begin
          if (gl_if.csr_resp_valid_i) begin
            if (gl_if.csr_resp_xcpt_i) begin
              w_xcpt  = 1'b1;
              w_cause = CAUSE_ILLEGAL_INSTR;
              w_pc    = w_s0.pc;
              w_flush = 1'b1;
              w_next  = ST_DRAIN;
            end else begin
              w_read_head = 2'b01;
              w_flush     = gl_if.csr_resp_flush_i;
              w_next      = gl_if.csr_resp_flush_i ? ST_DRAIN : ST_RUN;
            end
          end
        end
        ST_FENCE_WAIT: begin
          // Flush on both fence kinds so fence.i refetches from a clean front end.
          if (sb_empty_i) begin
            w_read_head = 2'b01;
            w_flush     = 1'b1;
            w_next      = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          w_next = ST_RUN;
        end
        default: begin
          w_next = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_RUN;
      r_csr_cnt   <= '0;
      r_fatal     <= 1'b0;
      r_csr_req   <= 1'b0;
      r_csr_addr  <= '0;
      r_csr_wdata <= '0;
    end else begin
      r_state   <= w_next;
      // Request stays up for every cycle spent waiting, including the response cycle.
      r_csr_req <= (w_next == ST_CSR_WAIT);
      if ((r_state == ST_RUN) && (w_next == ST_CSR_WAIT)) begin
        r_csr_addr  <= gl_if.gl_csr_addr_i;
        r_csr_wdata <= gl_if.gl_result_i;
        r_csr_cnt   <= '0;
      end else if (r_state == ST_CSR_WAIT) begin
        r_csr_cnt <= w_csr_cnt_inc;
        if (w_csr_cnt_inc == TIMEOUT_C) begin
          r_fatal <= 1'b1;
        end
      end
    end
  end

  assign gl_if.read_head_o     = w_read_head;
  assign gl_if.csr_req_valid_o = r_csr_req;
  assign gl_if.csr_addr_o      = r_csr_addr;
  assign gl_if.csr_wdata_o     = r_csr_wdata;

  assign flush_commit_o = w_flush;
  assign xcpt_valid_o   = w_xcpt;
  assign xcpt_cause_o   = w_cause;
  assign xcpt_tval_o    = w_tval;
  assign xcpt_pc_o      = w_pc;
  assign store_commit_o = (w_read_head[0] & is_store_or_amo(w_s0)) |
                          (w_read_head[1] & is_store_or_amo(w_s1));
  assign instret_inc_o  = {1'b0, w_read_head[0]} + {1'b0, w_read_head[1]};
  assign fatal_o        = r_fatal;

endmodule

// File: doc/commit_unit.md
# commit_unit

Retirement controller directly downstream of the graduation list. It examines the two oldest entries presented by the graduation list each cycle and retires zero, one or two of them by driving the graduation list's `read_head_i`. It serialises CSR instructions and fences, takes exceptions and interrupts precisely at the head, and raises the pipeline-wide `flush_commit` that empties the graduation list and the rest of the core.

## Interface
Parameters:
- `DUAL_COMMIT`, default 1: 1 allows two retirements per cycle; 0 limits retirement to slot 0 only.
- `CSR_TIMEOUT`, default 1023: maximum number of cycles in CSR_WAIT before `fatal_o` is raised.

Ports (all widths use `drac_pkg` types; "1" means a single bit):
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `gl_instr_i` in `gl_instruction_t[1:0]`: head (slot 0) and head+1 (slot 1) from the graduation list; `.valid=0` means the slot is not ready.
- `gl_exception_i` in `exception_t`: pending oldest exception from the graduation list.
- `gl_csr_addr_i` in `reg_csr_addr_t`: CSR address for a CSR at the head.
- `gl_result_i` in `bus64_t`: CSR write data.
- `interrupt_i` in 1: level-sensitive interrupt pending.
- `interrupt_cause_i` in `bus64_t`: interrupt cause.
- `csr_resp_valid_i` in 1: CSR unit finished the request.
- `csr_resp_xcpt_i` in 1: the CSR access faulted.
- `csr_resp_flush_i` in 1: the CSR write requires a refetch.
- `sb_empty_i` in 1: store buffer drained.
- `read_head_o` out 2: retire mask to the graduation list; bit 1 set implies bit 0 set.
- `flush_commit_o` out 1: one-cycle full pipeline flush.
- `store_commit_o` out 1: one retiring store/AMO released to the store buffer.
- `csr_req_valid_o` out 1: CSR access request.
- `csr_addr_o` out `reg_csr_addr_t`: registered CSR address.
- `csr_wdata_o` out `bus64_t`: registered CSR write data.
- `xcpt_valid_o` out 1: trap taken.
- `xcpt_cause_o` out `bus64_t`: trap cause.
- `xcpt_tval_o` out `bus64_t`: trap value.
- `xcpt_pc_o` out `addrPC_t`: PC of the trapping instruction.
- `instret_inc_o` out 2: number of instructions retired this cycle (0, 1 or 2).
- `fatal_o` out 1: sticky CSR timeout.

## Operation
State machine states: RUN, CSR_WAIT, FENCE_WAIT, DRAIN.

RUN, slot-0 priority, first match wins:
1. **Interrupt.** `interrupt_i` and slot 0 valid: trap with `interrupt_cause_i`, tval 0, `xcpt_pc_o` = slot-0 pc. No retire. Assert `flush_commit_o`. Go to DRAIN.
2. **Exception.** Slot-0 `ex_valid`: trap with `gl_exception_i` cause and tval. No retire. Assert `flush_commit_o`. Go to DRAIN.
3. **CSR.** Slot 0 is a CSR: latch `gl_csr_addr_i` and `gl_result_i`, go to CSR_WAIT. No retire.
4. **Fence.** Slot 0 is a fence or fence.i: go to FENCE_WAIT. No retire.
5. **Ordinary.** Otherwise slot 0 retires. Slot 1 also retires if all of the following hold:
   - `DUAL_COMMIT=1`;
   - slot 1 is valid;
   - slot 1 is not `ex_valid`, not a CSR and not a fence;
   - slot 0 and slot 1 are not both stores/AMOs (single store port).

`store_commit_o` is 1 when a retiring slot is a store or AMO.

CSR_WAIT:
- `csr_req_valid_o` is held at 1 until `csr_resp_valid_i`. The CSR counter increments every CSR_WAIT cycle.
- On response with xcpt: trap with the illegal-instruction cause, tval 0, pc = slot 0. Assert flush. Go to DRAIN.
- On response without xcpt: retire slot 0 only (`read_head_o=01`). Assert `flush_commit_o` if `csr_resp_flush_i`. Go to RUN, or to DRAIN if flushing.
- When the counter reaches `CSR_TIMEOUT`: set `fatal_o` and stay in CSR_WAIT.

FENCE_WAIT:
- When `sb_empty_i` is 1: retire slot 0, assert `flush_commit_o` (required for fence.i, applied to both fence kinds), go to DRAIN.

DRAIN:
- One cycle. `gl_instr_i` is ignored and nothing retires. Go to RUN.

Interrupts are sampled only in RUN and never interrupt CSR_WAIT or FENCE_WAIT.

## Timing
- `read_head_o`, `store_commit_o`, `instret_inc_o`, `flush_commit_o` and the `xcpt_*` outputs are combinational from state and inputs, valid in the same cycle the graduation list presents its head.
- `csr_req_valid_o`, `csr_addr_o` and `csr_wdata_o` are registered. The earliest request appears one cycle after the CSR reaches the head.
- The CSR response may arrive in the first CSR_WAIT cycle or later. Retirement happens in the response cycle.
- `flush_commit_o` and `xcpt_valid_o` are single-cycle pulses and never assert in consecutive cycles, because DRAIN always follows.
- Reset values: state RUN; `fatal_o`, counter, latched address and data all 0; every output 0.
- Reset asserted mid-CSR_WAIT returns to RUN without issuing a response-side retire.
- Both slots invalid, or graduation list empty: `read_head_o=00`, no state change.
- The CSR counter is 10 bits and saturates at `CSR_TIMEOUT`.

## Structure
- Add to `drac_pkg`:
  - `commit_state_t` enum.
  - `CAUSE_ILLEGAL_INSTR`, if not already present.
  - Helper functions `is_csr_instr`, `is_fence_instr` and `is_store_or_amo` on `gl_instruction_t`. Share `is_store_or_amo` with the graduation list.
- Single module, no sub-module. The CSR timeout counter stays inline.

## Test plan
- **Dual ordinary retire.** Two valid ALU ops at slots 0/1 → `read_head_o=11`, `instret_inc_o=2`, no flush.
- **Two stores.** Slot 0 and slot 1 both stores → `read_head_o=01`, `store_commit_o=1`. Next cycle slot 1 (new head) retires with `store_commit_o=1`.
- **CSR with refetch.** CSR at head with addr 0x300, data 0x8 → `csr_req_valid_o` the next cycle with those values. Response after 3 cycles with `csr_resp_flush_i=1` → `read_head_o=01` and `flush_commit_o` in the response cycle, then one DRAIN cycle.
- **Exception at head.** Slot-0 `ex_valid` with cause 0x5, tval 0x1000, pc 0x80000010 → `xcpt_valid_o=1` with those values, `read_head_o=00`, `flush_commit_o=1`, DRAIN next cycle.
- **Fence.** Fence at head with `sb_empty_i=0` for 4 cycles → no retire for 4 cycles. When `sb_empty_i` rises → retire plus flush.
- **CSR timeout and reset.** CSR unit never responds → `fatal_o=1` after 1023 CSR_WAIT cycles. `rst_i` asserted → `fatal_o=0`, state RUN.
